// File: rtl/output_pixel_writer_pkg.sv
// Types and constants shared by the output pixel writer, its interface and the bench.
package output_pixel_writer_pkg;

    typedef logic signed [7:0]  int8_t;
    typedef logic signed [31:0] int32_t;

    localparam int BYTES_PER_WORD = 4;
    localparam int LANE_W         = $clog2(BYTES_PER_WORD);

endpackage

// File: rtl/output_pixel_writer_if.sv
// Element stream in, tensor_ram write port out. The writer takes the slave side.
interface output_pixel_writer_if
    import output_pixel_writer_pkg::*;
#(
    parameter int DEPTH = 1024
);
    localparam int AW = $clog2(DEPTH);

    logic          valid_in;
    int8_t         data_in;
    logic          ready_out;
    logic          we;
    logic [AW-1:0] addr_w;
    logic [31:0]   din;

    modport slave (
        input  valid_in,
        input  data_in,
        output ready_out,
        output we,
        output addr_w,
        output din
    );

    modport master (
        output valid_in,
        output data_in,
        input  ready_out,
        input  we,
        input  addr_w,
        input  din
    );
endinterface

// File: rtl/output_pixel_writer_byte_packer.sv
// Collects int8 elements into little-endian 32-bit words. The outgoing word already
// contains the element being accepted, so the writer can register it in the same edge.
module byte_packer
    import output_pixel_writer_pkg::*;
(
    input  logic              clk,
    input  logic              reset,
    input  logic [LANE_W-1:0] lane,
    input  int8_t             elem,
    input  logic              accept,
    input  logic              flush,
    input  logic              clear,
    output logic [31:0]       word,
    output logic              word_done
);

    logic [31:0] pack_q;

    // Merge the incoming element into its lane; lanes above it are still zero.
    always_comb begin
        word = pack_q;
        if (accept) begin
            word[{lane, 3'b000} +: 8] = elem;
        end
    end

    assign word_done = accept && ((lane == LANE_W'(BYTES_PER_WORD - 1)) || flush);

    // Hold partial words; empty the register after every emitted word.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            pack_q <= '0;
        end else if (clear) begin
            pack_q <= '0;
        end else if (accept) begin
            pack_q <= word_done ? '0 : word;
        end
    end

endmodule

// File: rtl/output_pixel_writer.sv
// Packs a run of N_ELEMS int8 results into 32-bit words and writes them to tensor_ram
// starting at BASE_ADDR. A run starts on start and ends with a one-cycle done pulse
// that coincides with the final write.
module output_pixel_writer
    import output_pixel_writer_pkg::*;
#(
    parameter int DEPTH     = 1024,
    parameter int N_ELEMS   = 4096,
    parameter int BASE_ADDR = 0
)
(
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  start,
    output_pixel_writer_if.slave  pix,
    output logic                  busy,
    output logic                  done
);

    // state     | meaning
    // ST_IDLE   | waiting for start, elements refused
    // ST_RUN    | accepting elements, emitting words
    // ST_DONE   | final write on the port, done high
    typedef enum logic [1:0] {
        ST_IDLE,
        ST_RUN,
        ST_DONE
    } writer_state_t;

    localparam int AW      = $clog2(DEPTH);
    localparam int CNT_RAW = $clog2(N_ELEMS + 1);
    // At least two bits so the byte lane can always be sliced from the counter.
    localparam int CNT_W   = (CNT_RAW < LANE_W) ? LANE_W : CNT_RAW;

    writer_state_t  state;
    logic [CNT_W-1:0] elem_cnt;
    logic [AW-1:0]    word_addr;

    logic        accept;
    logic        last_elem;
    logic        start_run;
    logic [31:0] word;
    logic        word_done;

    assign pix.ready_out = (state == ST_RUN);
    assign accept        = pix.valid_in && pix.ready_out;
    assign last_elem     = (elem_cnt == CNT_W'(N_ELEMS - 1));
    assign start_run     = (state == ST_IDLE) && start;

    byte_packer u_byte_packer (
        .clk       (clk),
        .reset     (reset),
        .lane      (elem_cnt[LANE_W-1:0]),
        .elem      (pix.data_in),
        .accept    (accept),
        .flush     (last_elem),
        .clear     (start_run),
        .word      (word),
        .word_done (word_done)
    );

    // Run sequencing, element/word counters and the registered RAM write port.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state      <= ST_IDLE;
            elem_cnt   <= '0;
            word_addr  <= '0;
            pix.we     <= 1'b0;
            pix.addr_w <= '0;
            pix.din    <= '0;
            busy       <= 1'b0;
            done       <= 1'b0;
        end else begin
            pix.we <= 1'b0;
            done   <= 1'b0;
            case (state)
                ST_IDLE: begin
                    if (start) begin
                        state     <= ST_RUN;
                        elem_cnt  <= '0;
                        word_addr <= AW'(BASE_ADDR);
                        busy      <= 1'b1;
                    end
                end
                ST_RUN: begin
                    if (accept) begin
                        elem_cnt <= elem_cnt + 1'b1;
                        if (word_done) begin
                            pix.we     <= 1'b1;
                            pix.addr_w <= word_addr;
                            pix.din    <= word;
                            word_addr  <= word_addr + 1'b1;
                        end
                        if (last_elem) begin
                            state <= ST_DONE;
                            done  <= 1'b1;
                        end
                    end
                end
                ST_DONE: begin
                    state <= ST_IDLE;
                    busy  <= 1'b0;
                end
                default: begin
                    state <= ST_IDLE;
                    busy  <= 1'b0;
                end
            endcase
        end
    end

endmodule
